// File: rtl/soc_system_buttons_pio_0.sv
// ---------------------------------------------------------------------------
// soc_system_buttons_pio_0
//
// Avalon-MM slave input PIO for push-buttons/switches on the HPS-to-FPGA
// lightweight bus. The external inputs are synchronized, optionally
// debounced, and exposed on a data register. Selected edges are latched
// into a sticky edge-capture register, which drives a maskable level
// interrupt toward the HPS GIC.
//
// Optional feature macro: BUTTONS_PIO_DEBOUNCE_EN
//   defined   -> per-bit 16-bit stability counter between the synchronizer
//                and the edge detector (window = DEBOUNCE_CYCLES clocks)
//   undefined -> filter stage is a straight wire from the synchronizer
//
// Parameters:
//   WIDTH           number of input bits (1..32)
//   EDGE_TYPE       0 = rising, 1 = falling, 2 = any edge
//   RESET_MASK      reset value of the interrupt mask (low WIDTH bits used)
//   DEBOUNCE_CYCLES stability window in clocks (1..65535), debounce only
//
// Ports:
//   clk        in   single clock, all state on its rising edge
//   reset_n    in   asynchronous active-low reset
//   address    in   Avalon word address (0 data, 1 reserved, 2 mask, 3 edge)
//   chipselect in   Avalon slave select
//   write_n    in   active-low write strobe
//   writedata  in   write data
//   in_port    in   asynchronous external inputs
//   readdata   out  registered read data, zero-extended, latency 1
//   irq        out  level interrupt, OR of (edgecapture & interruptmask)
// ---------------------------------------------------------------------------
module soc_system_buttons_pio_0 #(
  parameter int          WIDTH           = 4,
  parameter int          EDGE_TYPE       = 1,
  parameter logic [31:0] RESET_MASK      = 32'd0,
  parameter int          DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  // Word addresses of the register map.
  localparam logic [1:0] LP_ADDR_DATA = 2'd0;
  localparam logic [1:0] LP_ADDR_RSVD = 2'd1;
  localparam logic [1:0] LP_ADDR_MASK = 2'd2;
  localparam logic [1:0] LP_ADDR_EDGE = 2'd3;

  // Edge selector encoding.
  localparam logic [1:0] LP_EDGE_SEL    = 2'(EDGE_TYPE);
  localparam logic [1:0] LP_EDGE_RISE   = 2'd0;
  localparam logic [1:0] LP_EDGE_FALL   = 2'd1;
  localparam logic [1:0] LP_EDGE_ANY    = 2'd2;

  // Warm-up counter terminal value: edge detection is enabled from here on.
  localparam logic [1:0] LP_WARM_DONE = 2'd3;

  // Reject illegal parameterizations at elaboration time.
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("soc_system_buttons_pio_0: WIDTH must be 1..32");
  end
  if (EDGE_TYPE < 0 || EDGE_TYPE > 2) begin : g_bad_edge
    $error("soc_system_buttons_pio_0: EDGE_TYPE must be 0, 1 or 2");
  end
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 65535) begin : g_bad_db
    $error("soc_system_buttons_pio_0: DEBOUNCE_CYCLES must be 1..65535");
  end

  // Upper write-data bits have no storage behind them.
  if (WIDTH < 32) begin : g_unused_wdata
    logic w_unused_wdata;
    assign w_unused_wdata = ^writedata[31:WIDTH];
  end

  // -------------------------------------------------------------------------
  // Declarations
  // -------------------------------------------------------------------------
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;
  logic [WIDTH-1:0] w_f;
  logic [WIDTH-1:0] r_f_d;
  logic [1:0]       r_warm;
  logic [WIDTH-1:0] w_edge_raw;
  logic [WIDTH-1:0] w_edge;
  logic [WIDTH-1:0] r_mask;
  logic [WIDTH-1:0] r_edge_cap;
  logic [31:0]      w_rd_mux;
  logic [31:0]      r_readdata;
  logic             w_wr;
  logic             w_rd;

  assign w_wr = chipselect & ~write_n;
  assign w_rd = chipselect &  write_n;

  // -------------------------------------------------------------------------
  // Input path
  // -------------------------------------------------------------------------

  // Two-flop synchronizer for the asynchronous button inputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_s1 <= {WIDTH{1'b0}};
      r_s2 <= {WIDTH{1'b0}};
    end else begin
      r_s1 <= in_port;
      r_s2 <= r_s1;
    end
  end

`ifdef BUTTONS_PIO_DEBOUNCE_EN
  localparam logic [15:0] LP_DB_LAST = 16'(DEBOUNCE_CYCLES - 1);

  logic [15:0]      r_db_cnt [WIDTH];
  logic [WIDTH-1:0] r_f;

  // Per-bit debounce: the filtered bit only follows s2 once s2 has held the
  // new value for the whole window; any return to the old value restarts it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_db_cnt[i] <= 16'd0;
      end
      r_f <= {WIDTH{1'b0}};
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (r_s2[i] == r_f[i]) begin
          r_db_cnt[i] <= 16'd0;
        end else if (r_db_cnt[i] == LP_DB_LAST) begin
          r_f[i]      <= r_s2[i];
          r_db_cnt[i] <= 16'd0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + 16'd1;
        end
      end
    end
  end

  assign w_f = r_f;
`else
  // No filtering: the data register sees the synchronizer output directly.
  assign w_f = r_s2;
`endif

  // Delayed copy of the filtered inputs plus the warm-up counter that keeps
  // edge detection off while the pipeline fills after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_f_d  <= {WIDTH{1'b0}};
      r_warm <= 2'd0;
    end else begin
      r_f_d <= w_f;
      if (r_warm != LP_WARM_DONE) begin
        r_warm <= r_warm + 2'd1;
      end else begin
        r_warm <= r_warm;
      end
    end
  end

  // Edge detection, selected at build time and gated by warm-up.
  always_comb begin
    w_edge_raw = {WIDTH{1'b0}};
    case (LP_EDGE_SEL)
      LP_EDGE_RISE: w_edge_raw =  w_f & ~r_f_d;
      LP_EDGE_FALL: w_edge_raw = ~w_f &  r_f_d;
      LP_EDGE_ANY:  w_edge_raw =  w_f ^  r_f_d;
      default:      w_edge_raw =  w_f ^  r_f_d;
    endcase
    if (r_warm == LP_WARM_DONE) begin
      w_edge = w_edge_raw;
    end else begin
      w_edge = {WIDTH{1'b0}};
    end
  end

  // -------------------------------------------------------------------------
  // Registers
  // -------------------------------------------------------------------------

  // Interrupt mask (RW) and edge capture (sticky, write-1-to-clear). The
  // new edge is OR-ed in after the clear so a same-cycle set wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_mask     <= RESET_MASK[WIDTH-1:0];
      r_edge_cap <= {WIDTH{1'b0}};
    end else begin
      if (w_wr && (address == LP_ADDR_MASK)) begin
        r_mask <= writedata[WIDTH-1:0];
      end else begin
        r_mask <= r_mask;
      end
      if (w_wr && (address == LP_ADDR_EDGE)) begin
        r_edge_cap <= (r_edge_cap & ~writedata[WIDTH-1:0]) | w_edge;
      end else begin
        r_edge_cap <= r_edge_cap | w_edge;
      end
    end
  end

  // Read multiplexer; unused upper bits stay zero.
  always_comb begin
    w_rd_mux = 32'd0;
    case (address)
      LP_ADDR_DATA: w_rd_mux[WIDTH-1:0] = w_f;
      LP_ADDR_RSVD: w_rd_mux            = 32'd0;
      LP_ADDR_MASK: w_rd_mux[WIDTH-1:0] = r_mask;
      LP_ADDR_EDGE: w_rd_mux[WIDTH-1:0] = r_edge_cap;
      default:      w_rd_mux            = 32'd0;
    endcase
  end

  // Read data register: loads on a selected read, otherwise holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_readdata <= 32'd0;
    end else if (w_rd) begin
      r_readdata <= w_rd_mux;
    end else begin
      r_readdata <= r_readdata;
    end
  end

  assign readdata = r_readdata;

  // Pure AND-OR of flop outputs, so the interrupt level cannot glitch from
  // bus activity.
  assign irq = |(r_edge_cap & r_mask);

endmodule
